// File: rtl/spart_tx_q.sv
// spart_tx_q: DEPTH-entry transmit queue feeding a UART serialiser (start, DATA_W data bits LSB first,
// optional parity, one or two stop bits). Define SPART_TX_PARITY_EN to build the parity stage.
module spart_tx_q #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic [1:0]               parity_mode,
    input  logic                     two_stop,
    output logic                     tx_q_full,
    output logic [$clog2(DEPTH):0]   tx_q_free,
    output logic                     tx_busy,
    output logic                     TX
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(16);
    localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SPART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // queue storage and bookkeeping
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_free;
    logic              r_full;

    // serialiser
    logic [2:0]        r_state;
    logic              r_tx;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_bit_idx;
    logic              r_two_stop;
    logic              r_stop_idx;
`ifdef SPART_TX_PARITY_EN
    logic              r_par_en;
    logic              r_par_val;
`else
    logic              w_unused_parity;
    assign w_unused_parity = ^parity_mode;
`endif

    logic              w_push;
    logic              w_pop;
    logic              w_not_empty;
    logic              w_bit_end;
    logic              w_last_stop;
    logic [CW-1:0]     w_count_next;
    logic [DIV_W-1:0]  w_div_clamped;
    logic [DATA_W-1:0] w_head;

    assign w_push        = wr_en & ~r_full;
    assign w_not_empty   = (r_count != '0);
    assign w_bit_end     = (r_cnt == '0);
    assign w_last_stop   = ~r_two_stop | r_stop_idx;
    // Pop from IDLE, or on the final stop-bit clock so the next start bit follows with no gap.
    assign w_pop         = w_not_empty &
                           ((r_state == S_IDLE) |
                            ((r_state == S_STOP) & w_bit_end & w_last_stop));
    assign w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_div_clamped = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
    assign w_head        = r_mem[r_rd_ptr];

    assign tx_q_full = r_full;
    assign tx_q_free = r_free;
    assign tx_busy   = (r_state != S_IDLE);
    assign TX        = r_tx;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_free   <= CW'(DEPTH);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_free  <= CW'(DEPTH) - w_count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_div      <= MIN_DIV;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_two_stop <= 1'b0;
            r_stop_idx <= 1'b0;
`ifdef SPART_TX_PARITY_EN
            r_par_en   <= 1'b0;
            r_par_val  <= 1'b0;
`endif
        end else if (w_pop) begin
            // Frame settings are captured here and held until the frame ends.
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_div      <= w_div_clamped;
            r_cnt      <= w_div_clamped - DIV_W'(1);
            r_shift    <= w_head;
            r_bit_idx  <= '0;
            r_two_stop <= two_stop;
            r_stop_idx <= 1'b0;
`ifdef SPART_TX_PARITY_EN
            r_par_en   <= (parity_mode == 2'b01) | (parity_mode == 2'b10);
            r_par_val  <= (^w_head) ^ (parity_mode == 2'b10);
`endif
        end else if (r_state != S_IDLE) begin
            if (!w_bit_end) begin
                r_cnt <= r_cnt - DIV_W'(1);
            end else begin
                r_cnt <= r_div - DIV_W'(1);
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                    S_DATA: begin
                        if (r_bit_idx == LAST_BIT) begin
`ifdef SPART_TX_PARITY_EN
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par_val;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
`ifdef SPART_TX_PARITY_EN
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
`endif
                    S_STOP: begin
                        if (!w_last_stop) begin
                            r_stop_idx <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_tx_q.sv
// Scoreboard bench for spart_tx_q: stimulus queues expected frames, a TX-line monitor checks every
// clock of each frame waveform against them. Honours SPART_TX_PARITY_EN like the design.
module tb_spart_tx_q;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DIV_W-1:0]  baud_div = 13'd16;
    logic [1:0]        parity_mode = 2'b00;
    logic              two_stop = 1'b0;
    logic              tx_q_full;
    logic [3:0]        tx_q_free;
    logic              tx_busy;
    logic              TX;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        int         baud;
        int         par;    // -1: no parity bit, else required parity bit value
        int         stops;
        bit         b2b;    // must start on the clock right after the previous stop bit
    } frame_t;

    frame_t exp_q[$];
    bit     mon_active = 1'b0;

    spart_tx_q #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
        .tx_q_full(tx_q_full), .tx_q_free(tx_q_free), .tx_busy(tx_busy), .TX(TX)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("check %s ok (0x%0h)", name, act);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int baud, input int par,
                                input int stops, input bit b2b);
        frame_t f;
        f.data = d; f.baud = baud; f.par = par; f.stops = stops; f.b2b = b2b;
        exp_q.push_back(f);
    endtask

    // Drive one write request, valid across exactly one rising edge.
    task automatic push_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((tx_busy || exp_q.size() != 0 || mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout: still busy/pending after %0d cycles, required idle", name, n);
        end
    endtask

    // Monitor: every frame on TX is compared clock by clock with the head of the scoreboard.
    initial begin
        int     idle_cnt;
        frame_t e;
        int     nbits;
        bit     bad;
        bit     abort;
        int     bad_bit;
        int     bad_k;
        logic   bad_val;
        logic   want;
        int     w;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                idle_cnt = 0;
            end else if (TX === 1'b1) begin
                idle_cnt++;
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: TX low at %0t, required idle (nothing queued)", $time);
                w = 0;
                while (TX !== 1'b1 && rst_n && w < 4000) begin
                    @(negedge clk);
                    w++;
                end
                idle_cnt = 0;
            end else begin
                mon_active = 1'b1;
                e = exp_q.pop_front();
                nbits = 1 + 8 + ((e.par >= 0) ? 1 : 0) + e.stops;
                bad = 1'b0; abort = 1'b0; bad_bit = 0; bad_k = 0; bad_val = 1'b0;
                for (int b = 0; b < nbits && !abort; b++) begin
                    if (b == 0)                      want = 1'b0;
                    else if (b <= 8)                 want = e.data[b-1];
                    else if (e.par >= 0 && b == 9)   want = e.par[0];
                    else                             want = 1'b1;
                    for (int k = 0; k < e.baud && !abort; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (!rst_n) abort = 1'b1;
                        else if (TX !== want && !bad) begin
                            bad = 1'b1; bad_bit = b; bad_k = k; bad_val = TX;
                        end
                    end
                end
                if (abort) begin
                    exp_q.delete();
                    $display("frame data=0x%02h cut short by reset", e.data);
                end else begin
                    if (e.b2b) begin
                        checks++;
                        if (idle_cnt != 0) begin
                            failures++;
                            $display("FAIL frame_gap data=0x%02h: idle gap %0d clk, required 0", e.data, idle_cnt);
                        end
                    end
                    checks++;
                    if (bad) begin
                        failures++;
                        $display("FAIL frame data=0x%02h: bit %0d clk %0d TX=%b, required %b",
                                 e.data, bad_bit, bad_k, bad_val, ~bad_val);
                    end else begin
                        $display("frame data=0x%02h baud=%0d par=%0d stops=%0d ok",
                                 e.data, e.baud, e.par, e.stops);
                    end
                end
                idle_cnt = 0;
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fill_vals [9];
        int         n;
        int         lows;
        int         par_even;
        int         par_odd;
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
`ifdef SPART_TX_PARITY_EN
        par_even = 1;
        par_odd  = 0;
`else
        par_even = -1;
        par_odd  = -1;
`endif

        // reset state
        @(negedge clk);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_free", 32'(tx_q_free), 32'd8);
        check("rst_full", 32'(tx_q_full), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 0xA5 at 16 clk/bit, no parity
        expect_frame(8'hA5, 16, -1, 1, 1'b0);
        push_byte(8'hA5);
        check("a5_free_after_write", 32'(tx_q_free), 32'd7);
        check("a5_tx_before_pop", 32'(TX), 32'd1);
        @(negedge clk);
        check("a5_free_after_pop", 32'(tx_q_free), 32'd8);
        check("a5_busy_at_start", 32'(tx_busy), 32'd1);
        check("a5_tx_start", 32'(TX), 32'd0);
        n = 0;
        while (tx_busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("a5_busy_cycles", 32'(n), 32'd160);
        wait_done("a5", 500);

        // parity: 0x07 even -> 1, odd -> 0 (ignored when parity is not built)
        parity_mode = 2'b01;
        expect_frame(8'h07, 16, par_even, 1, 1'b0);
        push_byte(8'h07);
        wait_done("par_even", 600);
        parity_mode = 2'b10;
        expect_frame(8'h07, 16, par_odd, 1, 1'b0);
        push_byte(8'h07);
        wait_done("par_odd", 600);
        parity_mode = 2'b00;

        // divisor below 16 clamps to 16
        baud_div = 13'd5;
        expect_frame(8'h3C, 16, -1, 1, 1'b0);
        push_byte(8'h3C);
        wait_done("clamp", 600);

        // fill the queue: one in flight plus DEPTH queued, then a dropped write
        baud_div = 13'd24;
        expect_frame(fill_vals[0], 24, -1, 1, 1'b0);
        push_byte(fill_vals[0]);
        @(negedge clk);
        check("fill_free_after_first", 32'(tx_q_free), 32'd8);
        for (int i = 1; i < 9; i++) begin
            expect_frame(fill_vals[i], 24, -1, 1, 1'b1);
            push_byte(fill_vals[i]);
        end
        check("fill_free_after_ninth", 32'(tx_q_free), 32'd0);
        check("fill_full", 32'(tx_q_full), 32'd1);
        push_byte(8'hEE);
        check("fill_free_after_drop", 32'(tx_q_free), 32'd0);
        check("fill_full_after_drop", 32'(tx_q_full), 32'd1);
        wait_done("fill", 3000);

        // two stop bits, back-to-back frames
        baud_div = 13'd16;
        two_stop = 1'b1;
        expect_frame(8'h5A, 16, -1, 2, 1'b0);
        expect_frame(8'hC3, 16, -1, 2, 1'b1);
        push_byte(8'h5A);
        push_byte(8'hC3);
        wait_done("two_stop", 1000);
        two_stop = 1'b0;

        // divisor change mid-frame only affects the next frame
        expect_frame(8'h81, 16, -1, 1, 1'b0);
        expect_frame(8'h7E, 32, -1, 1, 1'b1);
        push_byte(8'h81);
        push_byte(8'h7E);
        repeat (40) @(negedge clk);
        baud_div = 13'd32;
        wait_done("baud_change", 1200);
        baud_div = 13'd16;

        // reset during data bit 3 of 0xF0 with two more bytes queued
        expect_frame(8'hF0, 16, -1, 1, 1'b0);
        expect_frame(8'h0F, 16, -1, 1, 1'b1);
        expect_frame(8'h55, 16, -1, 1, 1'b1);
        push_byte(8'hF0);
        push_byte(8'h0F);
        push_byte(8'h55);
        repeat (66) @(negedge clk);
        check("rstmid_tx_bit3", 32'(TX), 32'd0);
        check("rstmid_free_before", 32'(tx_q_free), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_tx_async", 32'(TX), 32'd1);
        check("rstmid_free_async", 32'(tx_q_free), 32'd8);
        check("rstmid_busy_async", 32'(tx_busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rstrel_free", 32'(tx_q_free), 32'd8);
        check("rstrel_busy", 32'(tx_busy), 32'd0);
        check("rstrel_full", 32'(tx_q_full), 32'd0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        check("rstrel_no_frames", 32'(lows), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
